// File: rtl/button_debounce_stepper_pkg.sv
// Shared types and defaults for the push-button debouncer / LED stepper.
package button_debounce_stepper_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_UP_WAIT   = 2'd1,
        ST_DOWN      = 2'd2,
        ST_DOWN_WAIT = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEFAULT_CNT_W           = 18;
    localparam int unsigned DEFAULT_NUM_LEDS        = 5;

    // Map the raw pin to 1 = pressed regardless of board wiring.
    function automatic logic normalise_pin(input logic pin, input logic act_low);
        return pin ^ act_low;
    endfunction

endpackage

// File: rtl/button_debounce_stepper_if.sv
// Button pin in, debounced level / press pulse / LED bank out.
interface button_debounce_stepper_if #(
    parameter int unsigned NUM_LEDS = button_debounce_stepper_pkg::DEFAULT_NUM_LEDS
);
    logic                button;
    logic                level;
    logic                pressed;
    logic [NUM_LEDS-1:0] led;

    modport master (output button, input level, input pressed, input led);
    modport slave  (input button, output level, output pressed, output led);
endinterface

// File: rtl/button_debounce_stepper_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, reset to a chosen idle level.
module button_debounce_stepper_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/button_debounce_stepper.sv
// Synchronise and debounce a board push-button; each committed press steps a
// one-hot LED across the bank.
module button_debounce_stepper
    import button_debounce_stepper_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned NUM_LEDS        = DEFAULT_NUM_LEDS,
    parameter logic        BUTTON_ACT_LOW  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    button_debounce_stepper_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                pin_sync;
    logic                pressed_c;
    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                level_q,   level_d;
    logic                pressed_q, pressed_d;
    logic [NUM_LEDS-1:0] led_q,     led_d;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    button_debounce_stepper_sync_2ff #(
        .RESET_VAL (BUTTON_ACT_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.button),
        .q_o   (pin_sync)
    );

    assign pressed_c = normalise_pin(pin_sync, BUTTON_ACT_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pressed_q <= 1'b0;
            led_q     <= NUM_LEDS'(1);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pressed_q <= pressed_d;
            led_q     <= led_d;
        end
    end

    // Any sample disagreeing with the candidate level restarts qualification.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pressed_d = 1'b0;
        led_d     = led_q;
        unique case (state_q)
            ST_UP: begin
                if (pressed_c) begin
                    state_d = ST_UP_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_UP_WAIT: begin
                if (!pressed_c) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DOWN;
                    cnt_d     = '0;
                    level_d   = 1'b1;
                    pressed_d = 1'b1;
                    led_d     = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DOWN: begin
                if (!pressed_c) begin
                    state_d = ST_DOWN_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_DOWN_WAIT: begin
                if (pressed_c) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.level   = level_q;
    assign bus.pressed = pressed_q;
    assign bus.led     = led_q;
endmodule

// File: tb/tb_button_debounce_stepper.sv
// Scoreboard bench: active-high and active-low instances share one expected-event stream.
module tb_button_debounce_stepper;
    localparam int unsigned NL  = 5;
    localparam int          LAT = 6;

    typedef struct {
        int            cyc;
        logic          level;
        logic          pressed;
        logic [NL-1:0] led;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    logic [NL-1:0] exp_led = NL'(1);
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debounce_stepper_if #(.NUM_LEDS(NL)) bus0 ();
    button_debounce_stepper_if #(.NUM_LEDS(NL)) bus1 ();

    button_debounce_stepper #(
        .DEBOUNCE_CYCLES (4), .CNT_W (3), .NUM_LEDS (NL), .BUTTON_ACT_LOW (1'b0)
    ) u_dut0 (.clk (clk), .rst_n (rst_n), .bus (bus0));

    button_debounce_stepper #(
        .DEBOUNCE_CYCLES (4), .CNT_W (3), .NUM_LEDS (NL), .BUTTON_ACT_LOW (1'b1)
    ) u_dut1 (.clk (clk), .rst_n (rst_n), .bus (bus1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int idx, input logic lv, input logic pr, input logic [NL-1:0] ld);
        exp_t e;
        int   sz;
        sz = (idx == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_event cyc=%0d level=%b pressed=%b led=%b expected=no_event",
                     idx, cyc, lv, pr, ld);
        end else begin
            if (idx == 0) e = q0.pop_front();
            else          e = q1.pop_front();
            chk($sformatf("dut%0d_event_cycle", idx), 32'(cyc), 32'(e.cyc));
            chk($sformatf("dut%0d_event_level", idx), 32'(lv), 32'(e.level));
            chk($sformatf("dut%0d_event_pressed", idx), 32'(pr), 32'(e.pressed));
            chk($sformatf("dut%0d_event_led", idx), 32'(ld), 32'(e.led));
        end
    endtask

    // An event is any LEVEL edge or PRESSED pulse outside reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            if (bus0.level !== prev0 || bus0.pressed !== 1'b0)
                mon(0, bus0.level, bus0.pressed, bus0.led);
            if (bus1.level !== prev1 || bus1.pressed !== 1'b0)
                mon(1, bus1.level, bus1.pressed, bus1.led);
            prev0 = bus0.level;
            prev1 = bus1.level;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, output int c);
        bus0.button = v;
        bus1.button = ~v;
        c = cyc;
    endtask

    task automatic expect_evt(input int c, input logic lv, input logic pr);
        exp_t e;
        if (pr) exp_led = {exp_led[NL-2:0], exp_led[NL-1]};
        e.cyc     = c + LAT;
        e.level   = lv;
        e.pressed = pr;
        e.led     = exp_led;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic check_state(input string name, input logic lv, input logic pr, input logic [NL-1:0] ld);
        chk({name, "_dut0_level"},   32'(bus0.level),   32'(lv));
        chk({name, "_dut0_pressed"}, 32'(bus0.pressed), 32'(pr));
        chk({name, "_dut0_led"},     32'(bus0.led),     32'(ld));
        chk({name, "_dut1_level"},   32'(bus1.level),   32'(lv));
        chk({name, "_dut1_pressed"}, 32'(bus1.pressed), 32'(pr));
        chk({name, "_dut1_led"},     32'(bus1.led),     32'(ld));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            tick(1);
            n++;
        end
        chk({name, "_drain"}, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic press_release(input int hold);
        int c;
        drive(1'b1, c);
        expect_evt(c, 1'b1, 1'b1);
        tick(hold);
        drive(1'b0, c);
        expect_evt(c, 1'b0, 1'b0);
        tick(hold);
    endtask

    initial begin
        int c;
        bus0.button = 1'b0;
        bus1.button = 1'b1;
        tick(1);

        // Button held through reset: qualified after release.
        drive(1'b1, c);
        check_state("reset", 1'b0, 1'b0, 5'b00001);
        tick(3);
        check_state("reset_end", 1'b0, 1'b0, 5'b00001);
        rst_n = 1'b1;
        c = cyc;
        expect_evt(c, 1'b1, 1'b1);
        tick(15);
        drive(1'b0, c);
        expect_evt(c, 1'b0, 1'b0);
        tick(15);
        drain("s1");
        check_state("s1_end", 1'b0, 1'b0, 5'b00010);

        // Clean press, LED holds across release.
        press_release(20);
        drain("s2");
        check_state("s2_end", 1'b0, 1'b0, 5'b00100);

        // Bouncy press: short runs rejected, final stable run commits once.
        drive(1'b1, c); tick(1);
        drive(1'b0, c); tick(1);
        drive(1'b1, c); tick(2);
        drive(1'b0, c); tick(1);
        drive(1'b1, c);
        expect_evt(c, 1'b1, 1'b1);
        tick(20);
        drive(1'b0, c);
        expect_evt(c, 1'b0, 1'b0);
        tick(15);
        drain("s3");
        check_state("s3_end", 1'b0, 1'b0, 5'b01000);

        // Three-cycle glitch rejected; four-cycle pulse is the shortest accepted.
        drive(1'b1, c); tick(3);
        drive(1'b0, c); tick(15);
        drain("s4a");
        check_state("s4_glitch", 1'b0, 1'b0, 5'b01000);
        drive(1'b1, c);
        expect_evt(c, 1'b1, 1'b1);
        tick(4);
        drive(1'b0, c);
        expect_evt(c, 1'b0, 1'b0);
        tick(15);
        drain("s4b");
        check_state("s4_min_pulse", 1'b0, 1'b0, 5'b10000);

        // Wrap: five presses from reset walk the LED round the bank.
        rst_n = 1'b0;
        #1;
        exp_led = NL'(1);
        check_state("s5_reset", 1'b0, 1'b0, 5'b00001);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) press_release(10);
        drain("s5");
        check_state("s5_end", 1'b0, 1'b0, 5'b00001);

        // Reset while held: immediate clear, then one fresh press.
        press_release(10);
        drive(1'b1, c);
        expect_evt(c, 1'b1, 1'b1);
        tick(12);
        drain("s6a");
        check_state("s6_held", 1'b1, 1'b0, 5'b00100);
        rst_n = 1'b0;
        #1;
        exp_led = NL'(1);
        check_state("s6_reset", 1'b0, 1'b0, 5'b00001);
        tick(3);
        rst_n = 1'b1;
        c = cyc;
        expect_evt(c, 1'b1, 1'b1);
        tick(15);
        drive(1'b0, c);
        expect_evt(c, 1'b0, 1'b0);
        tick(15);
        drain("s6b");
        check_state("s6_end", 1'b0, 1'b0, 5'b00010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
